qspi_shift_engine: RTL and testbench
====================================

QSPI_SHIFT_ENGINE -- requirements
Module: qspi_shift_engine

Interface
REQ-001 Parameter: MAX_BYTES, default 4, maximum bytes per transfer; DATA_W = 8*MAX_BYTES.
REQ-002 h_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 h_rst  input  1  asynchronous, active-high reset.
REQ-004 sclk_in  input  1  divided SPI clock from the clock generator, synchronous to h_clk.
REQ-005 start  input  1  one-cycle transfer request.
REQ-006 len_in  input  2  byte count minus one (0 = 1 byte, 3 = 4 bytes).
REQ-007 quad_in  input  1  0 = single lane, 1 = quad lane.
REQ-008 rd_in  input  1  quad direction: 1 = read, 0 = write; ignored in single mode.
REQ-009 tx_data  input  DATA_W  transmit data, right-aligned.
REQ-010 io_in  input  4  pad input data.
REQ-011 io_out  output  4  pad output data.
REQ-012 io_oe  output  4  pad output enables.
REQ-013 cs_n  output  1  chip select, active low.
REQ-014 sclk_pin  output  1  gated SPI clock to pad.
REQ-015 rx_data  output  DATA_W  received data, right-aligned.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 Edge detect: sclk_q = sclk_in registered on h_clk; rise = sclk_in & ~sclk_q; fall = ~sclk_in & sclk_q.
REQ-019 Mode 0 timing: data launched on fall, sampled on rise, MSB first.
REQ-020 States: IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-021 IDLE: start with busy=0 latches len_in, quad_in, rd_in; loads tx_data left-shifted by 8*(MAX_BYTES-1-len_in); clears rx_data and bit counter; sets cs_n=0 and busy=1; drives first MSB bit(s) on io_out; next state SETUP.
REQ-022 start while busy=1 is ignored; no latched field changes.
REQ-023 SETUP: on first fall, set sclk_en=1 and enter SHIFT; no sampling occurs in SETUP.
REQ-024 sclk_pin = sclk_in AND sclk_en; sclk_en changes only in fall cycles, so the pin never glitches.
REQ-025 SHIFT on rise: single mode shifts io_in[1] into rx_data LSB, counter += 1; quad read shifts io_in[3:0], counter += 4; quad write samples nothing, counter += 4.
REQ-026 SHIFT on fall: tx shift register advances by 1 (single) or 4 (quad); io_out presents its top bit(s).
REQ-027 Bit counter is 6 bits; when a rise brings it to 8*(len+1), next state is HOLD and no further bits are launched.
REQ-028 HOLD: on next fall, sclk_en=0 and cs_n=1; next state DONE.
REQ-029 DONE: done=1 and busy=0 for one cycle; next state IDLE.
REQ-030 rx_data is stable from DONE until the next accepted start.
REQ-031 Single mode: io_oe=0001, io_out[0]=MOSI, full duplex.
REQ-032 Quad write: io_oe=1111; quad read: io_oe=0000.
REQ-033 IDLE: io_oe=0000 and io_out=0000.
REQ-034 Rise and fall never coincide; a simultaneous start and in-flight edge are impossible because start is ignored outside IDLE.

Reset
REQ-035 h_rst asserted, at any time including mid-transfer, forces immediately: state IDLE, cs_n=1, sclk_en=0 (sclk_pin=0), busy=0, done=0, io_oe=0000, io_out=0000, rx_data=0, counter=0, sclk_q=0.
REQ-036 After reset deasserts, the first fall is not acted upon unless the engine is in SETUP or SHIFT; no partial transfer resumes.

Verification
REQ-037 Single, len=0, tx=0xA5, MISO pattern 0x3C -> MOSI shows 1,0,1,0,0,1,0,1 across 8 falls; rx_data=0x0000003C; done one cycle after cs_n rises.
REQ-038 Quad write, len=3, tx=0x12345678 -> io_oe=1111; nibbles 1,2,...,8 over 8 rise edges; exactly 8 pulses on sclk_pin.
REQ-039 Quad read, len=1, io_in nibbles F,0,A,5 -> rx_data=0x0000F0A5; io_oe=0000 throughout.
REQ-040 start pulsed mid-transfer with different tx_data -> ignored; original data completes; exactly one done.
REQ-041 h_rst during SHIFT after 5 bits -> cs_n=1, sclk_pin=0, busy=0 immediately; next start runs a full clean transfer.
REQ-042 Clock divider value 0 (sclk toggling every h_clk) -> transfers still correct, with no sclk_pin glitch on the pin.

Source files
------------

// File: rtl/qspi_shift_engine.sv
// Single/quad-lane SPI shift engine (mode 0, MSB first) driven by an externally
// divided SPI clock. Both edges of that clock are detected in the h_clk domain.
module qspi_shift_engine #(
  parameter  int MAX_BYTES = 4,
  localparam int DATA_W    = 8 * MAX_BYTES
) (
  input  logic              h_clk,
  input  logic              h_rst,
  input  logic              sclk_in,
  input  logic              start,
  input  logic [1:0]        len_in,
  input  logic              quad_in,
  input  logic              rd_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic              cs_n,
  output logic              sclk_pin,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);

  localparam int SW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              sclk_q;
  logic [1:0]        len_q, len_d;
  logic              quad_q, quad_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_en_q, sclk_en_d;

  logic              rise, fall;
  logic [SW-1:0]     shamt;
  logic [DATA_W-1:0] tx_load;
  logic [5:0]        cnt_inc;
  logic [5:0]        cnt_tgt;

  assign rise = sclk_in & ~sclk_q;
  assign fall = ~sclk_in & sclk_q;

  // Right-aligned payload is pushed up so its first byte sits at the MSB.
  assign shamt   = SW'((MAX_BYTES - 1) * 8) - SW'({len_in, 3'b000});
  assign tx_load = tx_data << shamt;
  assign cnt_inc = cnt_q + (quad_q ? 6'd4 : 6'd1);
  assign cnt_tgt = 6'({len_q, 3'b000}) + 6'd8;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    quad_d    = quad_q;
    rd_d      = rd_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    cs_n_d    = cs_n_q;
    sclk_en_d = sclk_en_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_in;
          quad_d  = quad_in;
          rd_d    = rd_in;
          tx_d    = tx_load;
          rx_d    = '0;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (fall) begin
          sclk_en_d = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rise) begin
          cnt_d = cnt_inc;
          if (!quad_q) begin
            rx_d = {rx_q[DATA_W-2:0], io_in[1]};
          end else if (rd_q) begin
            rx_d = {rx_q[DATA_W-5:0], io_in};
          end
          if (cnt_inc == cnt_tgt) begin
            state_d = S_HOLD;
          end
        end else if (fall) begin
          tx_d = quad_q ? (tx_q << 4) : (tx_q << 1);
        end
      end
      S_HOLD: begin
        // Gating off on a fall cycle keeps the final pin pulse whole.
        if (fall) begin
          sclk_en_d = 1'b0;
          cs_n_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      len_q     <= '0;
      quad_q    <= 1'b0;
      rd_q      <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      cs_n_q    <= 1'b1;
      sclk_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_in;
      len_q     <= len_d;
      quad_q    <= quad_d;
      rd_q      <= rd_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      cs_n_q    <= cs_n_d;
      sclk_en_q <= sclk_en_d;
    end
  end

  always_comb begin
    io_oe  = 4'b0000;
    io_out = 4'b0000;
    if (state_q != S_IDLE) begin
      if (!quad_q) begin
        io_oe  = 4'b0001;
        io_out = {3'b000, tx_q[DATA_W-1]};
      end else if (!rd_q) begin
        io_oe  = 4'b1111;
        io_out = tx_q[DATA_W-1 -: 4];
      end
    end
  end

  assign sclk_pin = sclk_in & sclk_en_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_q;
  assign busy     = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_qspi_shift_engine.sv
// Directed bench for qspi_shift_engine: acts as the SPI slave, drives the
// divided clock and checks pin-level data, received data and handshake.
module tb_qspi_shift_engine;

  logic        h_clk = 1'b0;
  logic        h_rst = 1'b1;
  logic        sclk_in = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  len_in = 2'd0;
  logic        quad_in = 1'b0;
  logic        rd_in = 1'b0;
  logic [31:0] tx_data = 32'h0;
  logic [3:0]  io_in = 4'h0;
  logic [3:0]  io_out, io_oe;
  logic        cs_n, sclk_pin, busy, done;
  logic [31:0] rx_data;

  int tests = 0;
  int fails = 0;
  int div = 1;
  int dcnt = 0;
  int pin_edges = 0;

  logic [31:0] r_mosi;
  logic [3:0]  r_oe;
  logic        r_oe_var, r_timeout, r_busy_at_done;
  int          r_pulses, r_done_cnt, r_lat, r_edges;

  qspi_shift_engine #(.MAX_BYTES(4)) dut (
    .h_clk(h_clk), .h_rst(h_rst), .sclk_in(sclk_in), .start(start),
    .len_in(len_in), .quad_in(quad_in), .rd_in(rd_in), .tx_data(tx_data),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .cs_n(cs_n),
    .sclk_pin(sclk_pin), .rx_data(rx_data), .busy(busy), .done(done)
  );

  always #5 h_clk = ~h_clk;

  // Divided SPI clock: toggles every (div+1) h_clk cycles.
  always @(negedge h_clk) begin
    if (dcnt >= div) begin
      dcnt = 0;
      sclk_in = ~sclk_in;
    end else begin
      dcnt = dcnt + 1;
    end
  end

  always @(posedge sclk_pin) pin_edges = pin_edges + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] unit_val(input logic [31:0] m, input logic q, input int n, input int k);
    if (k >= n) return 4'h0;
    if (q) return 4'((m >> (4 * (n - 1 - k))) & 32'hF);
    return {2'b00, m[n-1-k], 1'b0};
  endfunction

  // Runs one transfer acting as slave; records what the pins showed.
  task automatic run_xfer(input logic [1:0] len, input logic quad, input logic rd,
                          input logic [31:0] tx, input logic [31:0] miso, input int inject_at);
    int nunits, k, cs_rise, done_at, after, e0;
    logic prev_pin, prev_cs;
    nunits = quad ? 2 * (int'(len) + 1) : 8 * (int'(len) + 1);
    k = 0; cs_rise = -1; done_at = -1; after = 0;
    r_mosi = 32'h0; r_oe = 4'h0; r_oe_var = 1'b0; r_timeout = 1'b1;
    r_busy_at_done = 1'b1; r_pulses = 0; r_done_cnt = 0;
    io_in = unit_val(miso, quad, nunits, 0);
    e0 = pin_edges;
    @(posedge h_clk); #1;
    len_in = len; quad_in = quad; rd_in = rd; tx_data = tx; start = 1'b1;
    @(posedge h_clk); #1;
    start = 1'b0;
    prev_pin = sclk_pin; prev_cs = cs_n;
    for (int i = 0; i < 3000; i++) begin
      @(posedge h_clk); #1;
      if (i == inject_at) begin
        start = 1'b1; tx_data = ~tx;
      end else begin
        start = 1'b0;
      end
      if (sclk_pin && !prev_pin) begin
        r_mosi = quad ? {r_mosi[27:0], io_out} : {r_mosi[30:0], io_out[0]};
        if (r_pulses == 0) r_oe = io_oe;
        else if (io_oe !== r_oe) r_oe_var = 1'b1;
        r_pulses++;
        k++;
        io_in = unit_val(miso, quad, nunits, k);
      end
      if (cs_n && !prev_cs && cs_rise < 0) cs_rise = i;
      if (done) begin
        r_done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          r_busy_at_done = busy;
        end
      end
      prev_pin = sclk_pin; prev_cs = cs_n;
      if (done_at >= 0) begin
        after++;
        if (after > 4) begin
          r_timeout = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    r_lat = (cs_rise < 0) ? -99 : done_at - cs_rise;
    r_edges = pin_edges - e0;
  endtask

  task automatic test_reset();
    h_rst = 1'b1;
    repeat (3) @(posedge h_clk);
    #1;
    tests++; if (cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (sclk_pin !== 1'b0) begin fails++; $display("FAIL reset_sclk_pin: got %b expected 0", sclk_pin); end
    tests++; if ({io_oe, io_out} !== 8'h00) begin fails++; $display("FAIL reset_io: got oe=%b out=%b expected 0000/0000", io_oe, io_out); end
    tests++; if (rx_data !== 32'h0) begin fails++; $display("FAIL reset_rx: got %h expected 00000000", rx_data); end
    h_rst = 1'b0;
    repeat (3) @(posedge h_clk);
    #1;
    tests++; if (cs_n !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_release_idle: got cs_n=%b busy=%b expected 1/0", cs_n, busy); end
  endtask

  task automatic test_single();
    div = 1;
    run_xfer(2'd0, 1'b0, 1'b0, 32'h000000A5, 32'h0000003C, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL single_timeout: no done within budget"); end
    tests++; if (r_mosi !== 32'h000000A5) begin fails++; $display("FAIL single_mosi: got %h expected 000000a5", r_mosi); end
    tests++; if (rx_data !== 32'h0000003C) begin fails++; $display("FAIL single_rx: got %h expected 0000003c", rx_data); end
    tests++; if (r_pulses != 8) begin fails++; $display("FAIL single_pulses: got %0d expected 8", r_pulses); end
    tests++; if (r_oe !== 4'b0001 || r_oe_var) begin fails++; $display("FAIL single_oe: got %b (varied=%b) expected 0001", r_oe, r_oe_var); end
    tests++; if (r_done_cnt != 1) begin fails++; $display("FAIL single_done_count: got %0d expected 1", r_done_cnt); end
    tests++; if (r_lat < 0 || r_lat > 1) begin fails++; $display("FAIL single_done_after_cs: got %0d cycles expected 0..1", r_lat); end
    tests++; if (r_busy_at_done !== 1'b0) begin fails++; $display("FAIL single_busy_at_done: got %b expected 0", r_busy_at_done); end
    tests++; if ({io_oe, io_out} !== 8'h00) begin fails++; $display("FAIL single_idle_io: got oe=%b out=%b expected 0000/0000", io_oe, io_out); end
  endtask

  task automatic test_quad_write();
    div = 1;
    run_xfer(2'd3, 1'b1, 1'b0, 32'h12345678, 32'h0, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL qwr_timeout: no done within budget"); end
    tests++; if (r_mosi !== 32'h12345678) begin fails++; $display("FAIL qwr_nibbles: got %h expected 12345678", r_mosi); end
    tests++; if (r_pulses != 8) begin fails++; $display("FAIL qwr_pulses: got %0d expected 8", r_pulses); end
    tests++; if (r_edges != 8) begin fails++; $display("FAIL qwr_pin_edges: got %0d expected 8", r_edges); end
    tests++; if (r_oe !== 4'b1111 || r_oe_var) begin fails++; $display("FAIL qwr_oe: got %b (varied=%b) expected 1111", r_oe, r_oe_var); end
    tests++; if (r_done_cnt != 1) begin fails++; $display("FAIL qwr_done_count: got %0d expected 1", r_done_cnt); end
  endtask

  task automatic test_quad_read();
    div = 1;
    run_xfer(2'd1, 1'b1, 1'b1, 32'h0000FFFF, 32'h0000F0A5, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL qrd_timeout: no done within budget"); end
    tests++; if (rx_data !== 32'h0000F0A5) begin fails++; $display("FAIL qrd_rx: got %h expected 0000f0a5", rx_data); end
    tests++; if (r_pulses != 4) begin fails++; $display("FAIL qrd_pulses: got %0d expected 4", r_pulses); end
    tests++; if (r_oe !== 4'b0000 || r_oe_var) begin fails++; $display("FAIL qrd_oe: got %b (varied=%b) expected 0000", r_oe, r_oe_var); end
  endtask

  task automatic test_back_to_back();
    div = 2;
    run_xfer(2'd1, 1'b0, 1'b0, 32'h0000C3A5, 32'h00001E96, 20);
    tests++; if (r_timeout) begin fails++; $display("FAIL b2b_timeout: no done within budget"); end
    tests++; if (r_mosi !== 32'h0000C3A5) begin fails++; $display("FAIL b2b_mosi: got %h expected 0000c3a5", r_mosi); end
    tests++; if (rx_data !== 32'h00001E96) begin fails++; $display("FAIL b2b_rx: got %h expected 00001e96", rx_data); end
    tests++; if (r_pulses != 16) begin fails++; $display("FAIL b2b_pulses: got %0d expected 16", r_pulses); end
    tests++; if (r_done_cnt != 1) begin fails++; $display("FAIL b2b_done_count: got %0d expected 1", r_done_cnt); end
    repeat (10) @(posedge h_clk);
    #1;
    tests++; if (rx_data !== 32'h00001E96) begin fails++; $display("FAIL b2b_rx_hold: got %h expected 00001e96", rx_data); end
  endtask

  task automatic test_reset_mid();
    int rises, e0;
    logic prev_pin, reached;
    div = 1;
    rises = 0; reached = 1'b0;
    io_in = 4'h2;
    @(posedge h_clk); #1;
    len_in = 2'd3; quad_in = 1'b0; rd_in = 1'b0; tx_data = 32'hCAFEF00D; start = 1'b1;
    @(posedge h_clk); #1;
    start = 1'b0;
    prev_pin = sclk_pin;
    for (int i = 0; i < 500; i++) begin
      @(posedge h_clk); #1;
      if (sclk_pin && !prev_pin) rises++;
      prev_pin = sclk_pin;
      if (rises == 5) begin
        reached = 1'b1;
        break;
      end
    end
    tests++; if (!reached) begin fails++; $display("FAIL rstmid_reach: got %0d bits expected 5", rises); end
    h_rst = 1'b1;
    #1;
    tests++; if (cs_n !== 1'b1) begin fails++; $display("FAIL rstmid_cs_n: got %b expected 1", cs_n); end
    tests++; if (sclk_pin !== 1'b0) begin fails++; $display("FAIL rstmid_sclk_pin: got %b expected 0", sclk_pin); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tests++; if ({io_oe, io_out} !== 8'h00) begin fails++; $display("FAIL rstmid_io: got oe=%b out=%b expected 0000/0000", io_oe, io_out); end
    tests++; if (rx_data !== 32'h0) begin fails++; $display("FAIL rstmid_rx: got %h expected 00000000", rx_data); end
    repeat (3) @(posedge h_clk);
    #1;
    h_rst = 1'b0;
    e0 = pin_edges;
    repeat (20) @(posedge h_clk);
    #1;
    tests++; if (cs_n !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_no_resume: got cs_n=%b busy=%b expected 1/0", cs_n, busy); end
    tests++; if (pin_edges != e0) begin fails++; $display("FAIL rstmid_no_pulses: got %0d edges expected 0", pin_edges - e0); end
    run_xfer(2'd3, 1'b0, 1'b0, 32'h89ABCDEF, 32'h2468ACE1, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL rstmid_timeout: no done within budget"); end
    tests++; if (r_mosi !== 32'h89ABCDEF) begin fails++; $display("FAIL rstmid_mosi: got %h expected 89abcdef", r_mosi); end
    tests++; if (rx_data !== 32'h2468ACE1) begin fails++; $display("FAIL rstmid_rx_after: got %h expected 2468ace1", rx_data); end
    tests++; if (r_pulses != 32 || r_done_cnt != 1) begin fails++; $display("FAIL rstmid_clean: got pulses=%0d done=%0d expected 32/1", r_pulses, r_done_cnt); end
  endtask

  task automatic test_fast_clock();
    div = 0;
    run_xfer(2'd3, 1'b0, 1'b0, 32'hDEADBEEF, 32'h13579BDF, -1);
    tests++; if (r_timeout) begin fails++; $display("FAIL fast_single_timeout: no done within budget"); end
    tests++; if (r_mosi !== 32'hDEADBEEF) begin fails++; $display("FAIL fast_single_mosi: got %h expected deadbeef", r_mosi); end
    tests++; if (rx_data !== 32'h13579BDF) begin fails++; $display("FAIL fast_single_rx: got %h expected 13579bdf", rx_data); end
    tests++; if (r_edges != 32 || r_pulses != 32) begin fails++; $display("FAIL fast_single_edges: got edges=%0d pulses=%0d expected 32/32", r_edges, r_pulses); end
    run_xfer(2'd2, 1'b1, 1'b0, 32'h00ABCDEF, 32'h0, -1);
    tests++; if (r_mosi !== 32'h00ABCDEF) begin fails++; $display("FAIL fast_qwr_nibbles: got %h expected 00abcdef", r_mosi); end
    tests++; if (r_edges != 6 || r_pulses != 6) begin fails++; $display("FAIL fast_qwr_edges: got edges=%0d pulses=%0d expected 6/6", r_edges, r_pulses); end
    run_xfer(2'd0, 1'b1, 1'b1, 32'h0, 32'h00000096, -1);
    tests++; if (rx_data !== 32'h00000096) begin fails++; $display("FAIL fast_qrd_rx: got %h expected 00000096", rx_data); end
    tests++; if (r_done_cnt != 1) begin fails++; $display("FAIL fast_qrd_done_count: got %0d expected 1", r_done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_quad_write();
    test_quad_read();
    test_back_to_back();
    test_reset_mid();
    test_fast_clock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
